param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//   Parametrised up/down counter with synchronous load, programmable modulus,
//   clock-enable prescaler and one-cycle terminal-count pulse. It extends the
//   8-bit load/output-enable counter with width, modulus, direction and tick-rate
//   generalisation. It sits behind the tile top level: count drives uo_out and
//   the output-enable bus drives uio_oe.
// PARAMETERS
//   WIDTH     8             counter / load / output width in bits (>=2)
//   MAX_VAL   2**WIDTH-1    top of count range; counts 0..MAX_VAL (MAX_VAL<2**WIDTH)
//   PRESCALE  1             enabled cycles per count tick (>=1; 1 = every cycle)
// PORTS
//   clk        in   1      clock; all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   en         in   1      count enable; gates the prescaler
//   load_en    in   1      synchronous load of load_val
//   dir        in   1      1 = count up, 0 = count down
//   oe         in   1      output-enable request
//   load_val   in   WIDTH  value loaded when load_en=1
//   count_val  out  WIDTH  registered count
//   count_oe   out  WIDTH  {WIDTH{oe}}, combinational
//   tc         out  1      registered terminal-count pulse, one cycle per boundary event
// BEHAVIOUR
//   - Reset (rst=1 at edge): count_val=0, prescaler=0, tc=0. count_oe follows oe.
//   - Priority per edge: rst > load_en > tick > hold.
//   - Load: count <= min(load_val, MAX_VAL); prescaler <= 0; tc <= 0. Visible next cycle.
//   - Prescaler: when en=1 and no load, pcnt increments; tick=1 when pcnt==PRESCALE-1,
//     and pcnt returns to 0 that edge. en=0 holds pcnt. PRESCALE=1 -> tick=en.
//   - Tick, dir=1: count==MAX_VAL -> boundary event; else count+1.
//   - Tick, dir=0: count==0 -> boundary event; else count-1.
//   - tc=1 for exactly the cycle after an edge carrying a boundary event; 0 otherwise.
//   - dir may change any cycle; it is sampled at tick only; prescaler is not reset.
//   - Load coincident with tick: load wins; no count step and no tc.
//   - en=0: count and tc=0 hold regardless of dir.
//   - Arithmetic is WIDTH bits; no intermediate wider than WIDTH+1; never exceeds MAX_VAL.
//   - Latency: one clock from tick/load to count_val; count_oe has zero latency.
// CONFIGURATION
//   COUNTER_SATURATE_EN defined: on a boundary event count holds (MAX_VAL up, 0 down),
//     and tc pulses on every tick that hits the bound (stays 1 under continuous ticks).
//   Undefined (default): on a boundary event count wraps (MAX_VAL->0 up, 0->MAX_VAL down),
//     and tc pulses once per wrap.
// STRUCTURE
//   counter_pkg: typedef count_dir_e {DIR_DOWN=0, DIR_UP=1}; localparam helpers
//     for prescaler width: $clog2(PRESCALE) with floor 1.
//   Sub-module tick_prescaler (params PRESCALE; ports clk, rst, en, clr, tick),
//     clr driven by load_en. Counter core, clamp and tc register live in this module.
// TESTING
//   1 rst=1 two cycles, oe=1 -> count_val=0, tc=0, count_oe=8'hFF.
//   2 WIDTH=8, MAX_VAL=9, dir=1, en=1 for 12 cycles -> 0..9,0,1; tc=1 only the cycle
//     count_val shows 0 after 9 (saturate build: holds 9, tc=1 from tick 10 on).
//   3 dir=0 from 0, en=1 -> next count_val=9, tc=1 (MAX_VAL=9, wrap build).
//   4 load_en=1, load_val=8'hC8 with MAX_VAL=9 -> count_val=9; load coincident with
//     a tick -> loaded value, tc=0.
//   5 PRESCALE=4, en=1 -> count steps every 4th cycle; en dropped 2 cycles mid-period
//     -> step delayed by exactly 2 cycles.
//   6 rst asserted mid-count (count=5, pcnt=2) -> next cycle count=0, pcnt=0, tc=0;
//     counting resumes a full PRESCALE period after rst deasserts.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction type and prescaler sizing helper for the up/down counter
package counter_pkg;
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} count_dir_e;
  function automatic int pcnt_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled cycles down to one count tick every PRESCALE enabled cycles
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = pcnt_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] r_pcnt;
  assign tick = en && !clr && (r_pcnt == LAST);
  // enabled-cycle counter; clr (a load) restarts the period, en=0 freezes it
  always_ff @(posedge clk)
    if (rst || clr) r_pcnt <= '0;
    else if (en) r_pcnt <= tick ? '0 : r_pcnt + 1'b1;
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter with clamped load, modulus, prescaled ticks and tc pulse; COUNTER_SATURATE_EN selects hold-at-bound instead of wrap
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_en,
  input  logic             dir,
  input  logic             oe,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_val,
  output logic [WIDTH-1:0] count_oe,
  output logic             tc
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             w_tick;
  logic             w_up;
  logic             w_at_bound;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_bound_val;
  logic [WIDTH-1:0] w_load;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load_en),
    .tick(w_tick)
  );
  assign w_up       = count_dir_e'(dir) == DIR_UP;
  assign w_at_bound = w_up ? (r_count == MAX) : (r_count == '0);
  assign w_step     = w_up ? r_count + 1'b1 : r_count - 1'b1;
  assign w_load     = (load_val > MAX) ? MAX : load_val;
`ifdef COUNTER_SATURATE_EN
  assign w_bound_val = r_count;
`else
  assign w_bound_val = w_up ? '0 : MAX;
`endif
  // count register and terminal-count pulse: reset, then load, then tick, else hold
  always_ff @(posedge clk)
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load_en) begin
      r_count <= w_load;
      r_tc    <= 1'b0;
    end else if (w_tick) begin
      r_count <= w_at_bound ? w_bound_val : w_step;
      r_tc    <= w_at_bound;
    end else r_tc <= 1'b0;
  assign count_val = r_count;
  assign tc        = r_tc;
  assign count_oe  = {WIDTH{oe}};
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed checks of counting, wrap/saturate, load clamp, prescaler and reset
module tb_param_updown_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load_en = 1'b0;
  logic       dir = 1'b1;
  logic       oe = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] c0, oe0, c4, oe4;
  logic       tc0, tc4;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  param_updown_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .load_en(load_en), .dir(dir), .oe(oe),
    .load_val(load_val), .count_val(c0), .count_oe(oe0), .tc(tc0)
  );
  param_updown_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .load_en(load_en), .dir(dir), .oe(oe),
    .load_val(load_val), .count_val(c4), .count_oe(oe4), .tc(tc4)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    load_en = 1'b0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    oe = 1'b1;
    en = 1'b1;
    step();
    step();
    checks++; if (c0 !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", c0); end
    checks++; if (tc0 !== 1'b0) begin failures++; $display("FAIL reset_tc got=%0b exp=0", tc0); end
    checks++; if (oe0 !== 8'hFF) begin failures++; $display("FAIL reset_oe got=%h exp=ff", oe0); end
    checks++; if (c4 !== 8'd0) begin failures++; $display("FAIL reset_count4 got=%0d exp=0", c4); end
    oe = 1'b0;
    #1;
    checks++; if (oe0 !== 8'h00) begin failures++; $display("FAIL oe_low got=%h exp=00", oe0); end
    oe = 1'b1;
    rst = 1'b0;
    en = 1'b0;
  endtask
  task automatic test_count_up();
    logic [7:0] exp_c;
    logic       exp_tc;
    dir = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
`ifdef COUNTER_SATURATE_EN
      exp_c  = (i > 9) ? 8'd9 : 8'(i);
      exp_tc = i >= 10;
`else
      exp_c  = 8'(i % 10);
      exp_tc = i == 10;
`endif
      checks++; if (c0 !== exp_c) begin failures++; $display("FAIL up_count[%0d] got=%0d exp=%0d", i, c0, exp_c); end
      checks++; if (tc0 !== exp_tc) begin failures++; $display("FAIL up_tc[%0d] got=%0b exp=%0b", i, tc0, exp_tc); end
    end
    en = 1'b0;
  endtask
  task automatic test_count_down();
    do_reset();
    dir = 1'b0;
    en = 1'b1;
    step();
`ifdef COUNTER_SATURATE_EN
    checks++; if (c0 !== 8'd0) begin failures++; $display("FAIL down_bound got=%0d exp=0", c0); end
`else
    checks++; if (c0 !== 8'd9) begin failures++; $display("FAIL down_wrap got=%0d exp=9", c0); end
`endif
    checks++; if (tc0 !== 1'b1) begin failures++; $display("FAIL down_tc got=%0b exp=1", tc0); end
    step();
`ifndef COUNTER_SATURATE_EN
    checks++; if (c0 !== 8'd8) begin failures++; $display("FAIL down_step got=%0d exp=8", c0); end
    checks++; if (tc0 !== 1'b0) begin failures++; $display("FAIL down_tc2 got=%0b exp=0", tc0); end
`endif
    en = 1'b0;
    dir = 1'b1;
  endtask
  task automatic test_load();
    do_reset();
    en = 1'b1;
    dir = 1'b1;
    load_en = 1'b1;
    load_val = 8'hC8;
    step();
    checks++; if (c0 !== 8'd9) begin failures++; $display("FAIL load_clamp got=%0d exp=9", c0); end
    checks++; if (tc0 !== 1'b0) begin failures++; $display("FAIL load_clamp_tc got=%0b exp=0", tc0); end
    load_val = 8'd3;
    step();
    checks++; if (c0 !== 8'd3) begin failures++; $display("FAIL load_at_bound got=%0d exp=3", c0); end
    checks++; if (tc0 !== 1'b0) begin failures++; $display("FAIL load_at_bound_tc got=%0b exp=0", tc0); end
    load_val = 8'd5;
    step();
    load_en = 1'b0;
    en = 1'b0;
    dir = 1'b0;
    step();
    step();
    checks++; if (c0 !== 8'd5) begin failures++; $display("FAIL hold_en0 got=%0d exp=5", c0); end
    checks++; if (tc0 !== 1'b0) begin failures++; $display("FAIL hold_en0_tc got=%0b exp=0", tc0); end
    en = 1'b1;
    step();
    checks++; if (c0 !== 8'd4) begin failures++; $display("FAIL load_then_down got=%0d exp=4", c0); end
    en = 1'b0;
    dir = 1'b1;
  endtask
  task automatic test_prescale();
    do_reset();
    dir = 1'b1;
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (c4 !== 8'(k / 4)) begin failures++; $display("FAIL pre_count[%0d] got=%0d exp=%0d", k, c4, k / 4); end
    end
    en = 1'b0;
    step();
    step();
    checks++; if (c4 !== 8'd2) begin failures++; $display("FAIL pre_pause got=%0d exp=2", c4); end
    en = 1'b1;
    step();
    checks++; if (c4 !== 8'd2) begin failures++; $display("FAIL pre_delayed got=%0d exp=2", c4); end
    step();
    checks++; if (c4 !== 8'd3) begin failures++; $display("FAIL pre_step got=%0d exp=3", c4); end
    en = 1'b0;
  endtask
  task automatic test_rst_mid();
    do_reset();
    dir = 1'b1;
    en = 1'b1;
    repeat (22) step();
    checks++; if (c4 !== 8'd5) begin failures++; $display("FAIL mid_setup got=%0d exp=5", c4); end
    rst = 1'b1;
    step();
    checks++; if (c4 !== 8'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", c4); end
    checks++; if (tc4 !== 1'b0) begin failures++; $display("FAIL mid_rst_tc got=%0b exp=0", tc4); end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (c4 !== 8'(k / 4)) begin failures++; $display("FAIL mid_resume[%0d] got=%0d exp=%0d", k, c4, k / 4); end
    end
    en = 1'b0;
  endtask
  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_prescale();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
